alu_ctrl: RTL and testbench
===========================

Name: alu_ctrl

Overview:
- Operand/sequencing stage directly upstream of the 8-bit `alu`. Owns a small register bank.
- Accepts one instruction per handshake and drives registered a/b/opcode into `alu`.
- Captures `resultado`/`zero` back into the bank and reports each result on a one-cycle strobe.
- Multi-cycle, non-pipelined: one instruction every 3 cycles at most.

Parameters:
- WIDTH, 8, data width; must match the `alu` operand width.
- NREGS, 4, register bank depth; power of two, minimum 2.
- OPW, 4, opcode width; must match the `alu` selection width.
- Derived constant (not overridable): AW = $clog2(NREGS), register address width.

Ports:
- clk  in  1  single clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept; high only in IDLE.
- in_opcode  in  OPW  ALU operation, passed through unmodified.
- in_rd  in  AW  destination register, also the source of operand a.
- in_rs  in  AW  source register for operand b.
- in_imm  in  WIDTH  immediate operand.
- in_use_imm  in  1  1: b = in_imm; 0: b = reg[in_rs].
- alu_a  out  WIDTH  registered operand a, to `alu` a.
- alu_b  out  WIDTH  registered operand b, to `alu` b.
- alu_opcode  out  OPW  registered opcode, to `alu` opcode.
- alu_resultado  in  WIDTH  from `alu` resultado.
- alu_zero  in  1  from `alu` zero.
- res_valid  out  1  one-cycle result strobe; no backpressure.
- res_data  out  WIDTH  captured result.
- res_zero  out  1  captured zero flag.
- res_rd  out  AW  register written by this result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: clk and synchronous active-high rst as above.
  - In the cycle after rst is sampled high: state=IDLE; all bank registers, alu_a, alu_b, alu_opcode, res_data, res_zero, res_rd = 0; res_valid = 0.
  - Reset mid-instruction aborts it: no bank write, no res_valid.
- States:
  - IDLE: in_ready=1.
  - EXEC: operands stable at the `alu`.
  - WB: result strobe cycle.
- IDLE -> EXEC on in_valid & in_ready (accept edge T):
  - alu_a <= reg[in_rd].
  - alu_b <= in_use_imm ? in_imm : reg[in_rs].
  - alu_opcode <= in_opcode.
  - latched rd <= in_rd.
- EXEC -> WB unconditionally. At that edge:
  - reg[rd] <= alu_resultado.
  - res_data <= alu_resultado, res_zero <= alu_zero, res_rd <= rd.
  - res_valid <= 1.
  - The `alu` is treated as purely combinational; one full EXEC cycle is allowed for settling.
- WB -> IDLE unconditionally. res_valid is high only during WB; res_data, res_zero and res_rd hold until the next WB.
- Latency: res_valid is high in the cycle after edge T+1, i.e. 2 edges after accept. Maximum throughput is one instruction per 3 cycles.
- in_valid while not IDLE is ignored: in_ready=0 and no input fields are sampled. The upstream block must hold its fields stable until accepted.
- No hazards exist: writeback completes before the next accept, so back-to-back dependent instructions see updated values.
- rd == rs is legal: both operands read the pre-write value.
- alu_a, alu_b and alu_opcode retain their values in IDLE and WB (no glitching at the `alu`).
- Arithmetic lives entirely in the `alu`; this block never modifies widths. Overflow and wrap-around are whatever `alu` produces on WIDTH bits.

Optional Feature:
- Macro: ALU_CTRL_DBG_PORT_EN.
- Defined: adds ports dbg_addr (in, AW) and dbg_data (out, WIDTH).
  - dbg_data = reg[dbg_addr], combinational.
  - Shows the post-write value from the cycle after the write edge.
  - Reads have no side effects.
- Undefined: the ports are absent and no read mux is generated. All other behaviour is identical.

Decomposition:
- Shared package `alu_pkg`:
  - state encoding typedef (IDLE=2'd0, EXEC=2'd1, WB=2'd2; 2'd3 illegal, recovers to IDLE);
  - default WIDTH/OPW constants, also reused by `alu`.
- One natural sub-module, `alu_regbank`:
  - NREGS x WIDTH, two combinational read ports, one synchronous write port;
  - synchronous reset to 0.
- The FSM and the operand/result registers stay in `alu_ctrl`.

Test Plan:
- Bench stub ALU, same ports as `alu`: opcode 0 -> a+b; 1 -> a-b; other -> a. zero = (result==0).
- Scenarios:
  - Reset, then accept {op=0, rd=1, imm=8'h0A, use_imm=1} -> alu_a=0, alu_b=0x0A. Two edges later: res_valid for exactly 1 cycle, res_data=0x0A, res_zero=0, res_rd=1.
  - Then {op=0, rd=1, imm=8'h02, use_imm=1} -> res_data=0x0C. Then {op=1, rd=1, rs=1, use_imm=0} -> res_data=0x00, res_zero=1.
  - Wrap-around: reg2 loaded with 0xFF, then {op=0, rd=2, imm=1, use_imm=1} -> res_data=0x00, res_zero=1.
  - in_valid held high continuously -> in_ready high only every 3rd cycle, exactly one accept per 3 cycles, and fields changed while busy are ignored.
  - rst asserted during EXEC -> next cycle state IDLE, res_valid=0, target register still 0.
  - With ALU_CTRL_DBG_PORT_EN defined: after a write of 0x0C to reg1, dbg_addr=1 -> dbg_data=0x0C.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu operand/sequencing stage and the alu itself:
// sequencer state encoding and default datapath widths.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;
    localparam int unsigned ALU_OPW   = 4;
    localparam int unsigned ALU_NREGS = 4;

    // 2'd3 is unused and steers back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_regbank.sv
// NREGS x WIDTH register bank: two combinational read ports, one synchronous write port.
// With ALU_CTRL_DBG_PORT_EN defined a third read port feeds the debug output.
module alu_regbank
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned NREGS = ALU_NREGS,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
`ifdef ALU_CTRL_DBG_PORT_EN
    ,
    input  logic [AW-1:0]    raddr_dbg,
    output logic [WIDTH-1:0] rdata_dbg
`endif
);

    logic [WIDTH-1:0] regs [NREGS];

    // Reset wins over a pending write, so an aborted instruction leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

`ifdef ALU_CTRL_DBG_PORT_EN
    assign rdata_dbg = regs[raddr_dbg];
`endif

endmodule

// File: rtl/alu_ctrl.sv
// Operand/sequencing stage in front of the 8-bit alu: IDLE -> EXEC -> WB per instruction.
// Optional debug read port enabled by defining ALU_CTRL_DBG_PORT_EN.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned NREGS = ALU_NREGS,
    parameter int unsigned OPW   = ALU_OPW,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_opcode,
    input  logic [AW-1:0]    in_rd,
    input  logic [AW-1:0]    in_rs,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_use_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_resultado,
    input  logic             alu_zero,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic [AW-1:0]    res_rd,
    output logic             busy
`ifdef ALU_CTRL_DBG_PORT_EN
    ,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
`endif
);

    state_e           state;
    logic [AW-1:0]    rd_q;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             wr_en_c;

    // Writeback happens on the EXEC -> WB edge, after a full cycle of alu settling.
    assign wr_en_c = (state == ST_EXEC);

    alu_regbank #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regbank (
        .clk       (clk),
        .rst       (rst),
        .we        (wr_en_c),
        .waddr     (rd_q),
        .wdata     (alu_resultado),
        .raddr_a   (in_rd),
        .rdata_a   (rdata_a),
        .raddr_b   (in_rs),
        .rdata_b   (rdata_b)
`ifdef ALU_CTRL_DBG_PORT_EN
        ,
        .raddr_dbg (dbg_addr),
        .rdata_dbg (dbg_data)
`endif
    );

    // Sequencer; in_ready/busy are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rd_q       <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_zero   <= 1'b0;
            res_rd     <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        alu_a      <= rdata_a;
                        alu_b      <= in_use_imm ? in_imm : rdata_b;
                        alu_opcode <= in_opcode;
                        rd_q       <= in_rd;
                        state      <= ST_EXEC;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    res_data  <= alu_resultado;
                    res_zero  <= alu_zero;
                    res_rd    <= rd_q;
                    res_valid <= 1'b1;
                    state     <= ST_WB;
                end
                ST_WB: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl with a stub combinational alu.
// Debug-port checks compile in when ALU_CTRL_DBG_PORT_EN is defined.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic [1:0] in_rd;
    logic [1:0] in_rs;
    logic [7:0] in_imm;
    logic       in_use_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_resultado;
    logic       alu_zero;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_zero;
    logic [1:0] res_rd;
    logic       busy;
`ifdef ALU_CTRL_DBG_PORT_EN
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stub alu: 0 -> a+b, 1 -> a-b, otherwise a.
    always_comb begin
        case (alu_opcode)
            4'd0:    alu_resultado = alu_a + alu_b;
            4'd1:    alu_resultado = alu_a - alu_b;
            default: alu_resultado = alu_a;
        endcase
        alu_zero = (alu_resultado == 8'h00);
    end

    alu_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_rd         (in_rd),
        .in_rs         (in_rs),
        .in_imm        (in_imm),
        .in_use_imm    (in_use_imm),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_opcode    (alu_opcode),
        .alu_resultado (alu_resultado),
        .alu_zero      (alu_zero),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_zero      (res_zero),
        .res_rd        (res_rd),
        .busy          (busy)
`ifdef ALU_CTRL_DBG_PORT_EN
        ,
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
`endif
    );

    // Offer one instruction at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [7:0] imm, input logic use_imm);
        int wait_cycles = 0;
        @(negedge clk);
        while (!in_ready && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, wait_cycles);
        end
        in_valid   = 1'b1;
        in_opcode  = op;
        in_rd      = rd;
        in_rs      = rs;
        in_imm     = imm;
        in_use_imm = use_imm;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, busy, res_valid} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl: ready/busy/valid=%b required 100", {in_ready, busy, res_valid});
        end
        checks++;
        if ({alu_a, alu_b, alu_opcode, res_data, res_zero, res_rd} !== 31'd0) begin
            errors++;
            $display("FAIL reset_regs: a=%h b=%h op=%h data=%h zero=%b rd=%0d required all 0",
                     alu_a, alu_b, alu_opcode, res_data, res_zero, res_rd);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        send(4'd0, 2'd1, 2'd0, 8'h0A, 1'b1);
        checks++;
        if (alu_a !== 8'h00 || alu_b !== 8'h0A || alu_opcode !== 4'd0) begin
            errors++;
            $display("FAIL basic_operands: a=%h b=%h op=%h required 00 0a 0", alu_a, alu_b, alu_opcode);
        end
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_exec: valid=%b ready=%b busy=%b required 0 0 1", res_valid, in_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h0A || res_zero !== 1'b0 || res_rd !== 2'd1) begin
            errors++;
            $display("FAIL basic_result: valid=%b data=%h zero=%b rd=%0d required 1 0a 0 1",
                     res_valid, res_data, res_zero, res_rd);
        end
        checks++;
        if (alu_a !== 8'h00 || alu_b !== 8'h0A) begin
            errors++;
            $display("FAIL basic_hold_wb: a=%h b=%h required 00 0a", alu_a, alu_b);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || res_data !== 8'h0A) begin
            errors++;
            $display("FAIL basic_strobe_end: valid=%b ready=%b busy=%b data=%h required 0 1 0 0a",
                     res_valid, in_ready, busy, res_data);
        end
    endtask

    task automatic test_dependent();
        send(4'd0, 2'd1, 2'd0, 8'h02, 1'b1);
        checks++;
        if (alu_a !== 8'h0A || alu_b !== 8'h02) begin
            errors++;
            $display("FAIL dep_operands: a=%h b=%h required 0a 02", alu_a, alu_b);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h0C || res_zero !== 1'b0) begin
            errors++;
            $display("FAIL dep_add: valid=%b data=%h zero=%b required 1 0c 0", res_valid, res_data, res_zero);
        end
`ifdef ALU_CTRL_DBG_PORT_EN
        dbg_addr = 2'd1;
        #1;
        checks++;
        if (dbg_data !== 8'h0C) begin
            errors++;
            $display("FAIL dbg_read: dbg_data=%h required 0c", dbg_data);
        end
`endif
        // rd == rs: both operands see the pre-write value 0x0C.
        send(4'd1, 2'd1, 2'd1, 8'hEE, 1'b0);
        checks++;
        if (alu_a !== 8'h0C || alu_b !== 8'h0C || alu_opcode !== 4'd1) begin
            errors++;
            $display("FAIL sub_operands: a=%h b=%h op=%h required 0c 0c 1", alu_a, alu_b, alu_opcode);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h00 || res_zero !== 1'b1 || res_rd !== 2'd1) begin
            errors++;
            $display("FAIL sub_result: valid=%b data=%h zero=%b rd=%0d required 1 00 1 1",
                     res_valid, res_data, res_zero, res_rd);
        end
    endtask

    task automatic test_wrap();
        send(4'd0, 2'd2, 2'd0, 8'hFF, 1'b1);
        @(negedge clk);
        checks++;
        if (res_data !== 8'hFF || res_rd !== 2'd2) begin
            errors++;
            $display("FAIL wrap_load: data=%h rd=%0d required ff 2", res_data, res_rd);
        end
        send(4'd0, 2'd2, 2'd0, 8'h01, 1'b1);
        checks++;
        if (alu_a !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_operand: a=%h required ff", alu_a);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h00 || res_zero !== 1'b1) begin
            errors++;
            $display("FAIL wrap_result: valid=%b data=%h zero=%b required 1 00 1", res_valid, res_data, res_zero);
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        in_valid   = 1'b1;
        in_opcode  = 4'd0;
        in_rd      = 2'd3;
        in_rs      = 2'd0;
        in_use_imm = 1'b1;
        for (int i = 0; i < 9; i++) begin
            // Fields only carry imm=1 while ready; the busy-time values must be ignored.
            in_imm = in_ready ? 8'h01 : 8'(8'h50 + i);
            checks++;
            if (in_ready !== (i % 3 == 0)) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: in_ready=%b required %b", i, in_ready, (i % 3 == 0));
            end
            checks++;
            if (res_valid !== (i % 3 == 2) || (i % 3 == 2 && res_data !== 8'(i / 3 + 1))) begin
                errors++;
                $display("FAIL b2b_result[%0d]: valid=%b data=%h required %b %h",
                         i, res_valid, res_data, (i % 3 == 2), 8'(i / 3 + 1));
            end
            if (in_ready) accepts++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (accepts != 3) begin
            errors++;
            $display("FAIL b2b_accepts: accepts=%0d required 3", accepts);
        end
    endtask

    task automatic test_reset_mid();
        send(4'd0, 2'd0, 2'd0, 8'h33, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || alu_a !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_state: valid=%b ready=%b busy=%b a=%h required 0 1 0 00",
                     res_valid, in_ready, busy, alu_a);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_nostrobe: valid=%b required 0", res_valid);
        end
        // Pass-through opcode reads reg0 back through the result path.
        send(4'd5, 2'd0, 2'd0, 8'h77, 1'b1);
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h00 || res_zero !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_reg0: valid=%b data=%h zero=%b required 1 00 1", res_valid, res_data, res_zero);
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_opcode  = '0;
        in_rd      = '0;
        in_rs      = '0;
        in_imm     = '0;
        in_use_imm = 1'b0;
`ifdef ALU_CTRL_DBG_PORT_EN
        dbg_addr   = '0;
`endif
        test_reset();
        test_basic();
        test_dependent();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
